// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures decoded operands/control, bypasses same-cycle
// writeback, detects load-use hazards and counts stall/flush events.
module id_ex_stage #(
   parameter int XLEN = 64,
   parameter int CNTW = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            id_valid,
   input  logic [XLEN-1:0] id_pc,
   input  logic [4:0]      id_rs1,
   input  logic [4:0]      id_rs2,
   input  logic [4:0]      id_rd,
   input  logic            id_uses_rs1,
   input  logic            id_uses_rs2,
   input  logic [XLEN-1:0] id_rs1_data,
   input  logic [XLEN-1:0] id_rs2_data,
   input  logic [XLEN-1:0] id_imm,
   input  logic            id_reg_write,
   input  logic            id_mem_read,
   input  logic            id_mem_write,
   input  logic            id_alu_src,
   input  logic [3:0]      id_alu_op,
   input  logic            wb_reg_write,
   input  logic [4:0]      wb_rd,
   input  logic [XLEN-1:0] wb_data,
   input  logic            ex_flush,
   input  logic            ex_hold,
   output logic            stall_if_id,
   output logic            ex_valid,
   output logic [XLEN-1:0] ex_pc,
   output logic [XLEN-1:0] ex_imm,
   output logic [XLEN-1:0] ex_rs1_data,
   output logic [XLEN-1:0] ex_rs2_data,
   output logic [4:0]      ex_rs1,
   output logic [4:0]      ex_rs2,
   output logic [4:0]      ex_rd,
   output logic            ex_reg_write,
   output logic            ex_mem_read,
   output logic            ex_mem_write,
   output logic            ex_alu_src,
   output logic [3:0]      ex_alu_op,
   output logic [CNTW-1:0] stall_count,
   output logic [CNTW-1:0] flush_count
);

   // Handshake: id_valid marks a real instruction in ID; stall_if_id is the
   // upstream "not ready" and the ID slot must stay unchanged while it is high.
   // ex_hold is the downstream "not ready"; EX contents are frozen while it is high.
   logic            lu;
   logic            bubble;
   logic            advance;
   logic [XLEN-1:0] rs1_fwd;
   logic [XLEN-1:0] rs2_fwd;

   always_comb begin
      lu = ex_valid & ex_mem_read & (ex_rd != 5'd0) & id_valid &
           ((id_uses_rs1 & (id_rs1 == ex_rd)) | (id_uses_rs2 & (id_rs2 == ex_rd)));
      stall_if_id = !ex_flush & (ex_hold | lu);
      bubble      = ex_flush | (!ex_hold & lu);
      advance     = !ex_flush & !ex_hold & !lu;
   end

   // x0 always reads zero, even if a writeback targets it.
   always_comb begin
      rs1_fwd = id_rs1_data;
      if (id_rs1 == 5'd0)
         rs1_fwd = '0;
      else if (wb_reg_write && (wb_rd == id_rs1))
         rs1_fwd = wb_data;
      rs2_fwd = id_rs2_data;
      if (id_rs2 == 5'd0)
         rs2_fwd = '0;
      else if (wb_reg_write && (wb_rd == id_rs2))
         rs2_fwd = wb_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_valid     <= 1'b0;
         ex_pc        <= '0;
         ex_imm       <= '0;
         ex_rs1_data  <= '0;
         ex_rs2_data  <= '0;
         ex_rs1       <= '0;
         ex_rs2       <= '0;
         ex_rd        <= '0;
         ex_reg_write <= 1'b0;
         ex_mem_read  <= 1'b0;
         ex_mem_write <= 1'b0;
         ex_alu_src   <= 1'b0;
         ex_alu_op    <= '0;
      end else if (bubble) begin
         ex_valid     <= 1'b0;
         ex_reg_write <= 1'b0;
         ex_mem_read  <= 1'b0;
         ex_mem_write <= 1'b0;
         ex_alu_src   <= 1'b0;
         ex_alu_op    <= '0;
      end else if (advance) begin
         ex_valid     <= id_valid;
         ex_pc        <= id_pc;
         ex_imm       <= id_imm;
         ex_rs1_data  <= rs1_fwd;
         ex_rs2_data  <= rs2_fwd;
         ex_rs1       <= id_rs1;
         ex_rs2       <= id_rs2;
         ex_rd        <= id_rd;
         ex_reg_write <= id_valid & id_reg_write;
         ex_mem_read  <= id_valid & id_mem_read;
         ex_mem_write <= id_valid & id_mem_write;
         ex_alu_src   <= id_valid & id_alu_src;
         ex_alu_op    <= id_valid ? id_alu_op : 4'd0;
      end
   end

   // Saturating event counters; they stick at all-ones.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_count <= '0;
         flush_count <= '0;
      end else begin
         if (stall_if_id && (stall_count != '1))
            stall_count <= stall_count + 1'b1;
         if (ex_flush && (flush_count != '1))
            flush_count <= flush_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, advance, bypass, load-use, hold,
// flush priority, counter saturation (CNTW=4) and asynchronous reset.
module tb_id_ex_stage;

   localparam int XLEN = 64;
   localparam int CNTW = 4;

   logic            clk;
   logic            rst_n;
   logic            id_valid;
   logic [XLEN-1:0] id_pc;
   logic [4:0]      id_rs1, id_rs2, id_rd;
   logic            id_uses_rs1, id_uses_rs2;
   logic [XLEN-1:0] id_rs1_data, id_rs2_data, id_imm;
   logic            id_reg_write, id_mem_read, id_mem_write, id_alu_src;
   logic [3:0]      id_alu_op;
   logic            wb_reg_write;
   logic [4:0]      wb_rd;
   logic [XLEN-1:0] wb_data;
   logic            ex_flush, ex_hold;
   logic            stall_if_id, ex_valid;
   logic [XLEN-1:0] ex_pc, ex_imm, ex_rs1_data, ex_rs2_data;
   logic [4:0]      ex_rs1, ex_rs2, ex_rd;
   logic            ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src;
   logic [3:0]      ex_alu_op;
   logic [CNTW-1:0] stall_count, flush_count;

   int checks;
   int failures;

   id_ex_stage #(.XLEN(XLEN), .CNTW(CNTW)) dut (
      .clk(clk), .rst_n(rst_n),
      .id_valid(id_valid), .id_pc(id_pc),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
      .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
      .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
      .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
      .id_mem_write(id_mem_write), .id_alu_src(id_alu_src), .id_alu_op(id_alu_op),
      .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
      .ex_flush(ex_flush), .ex_hold(ex_hold),
      .stall_if_id(stall_if_id), .ex_valid(ex_valid),
      .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
      .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
      .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
      .ex_mem_write(ex_mem_write), .ex_alu_src(ex_alu_src), .ex_alu_op(ex_alu_op),
      .stall_count(stall_count), .flush_count(flush_count)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Inputs change 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_id(input logic v, input logic [63:0] pc, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic [4:0] rd,
                           input logic u1, input logic u2, input logic rw, input logic mr);
      id_valid     = v;
      id_pc        = pc;
      id_rs1       = rs1;
      id_rs2       = rs2;
      id_rd        = rd;
      id_uses_rs1  = u1;
      id_uses_rs2  = u2;
      id_reg_write = rw;
      id_mem_read  = mr;
   endtask

   initial begin
      checks = 0;
      failures = 0;
      rst_n = 1'b0;
      drive_id(1'b0, 64'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      id_rs1_data = '0; id_rs2_data = '0; id_imm = '0;
      id_mem_write = 1'b0; id_alu_src = 1'b0; id_alu_op = '0;
      wb_reg_write = 1'b0; wb_rd = '0; wb_data = '0;
      ex_flush = 1'b0; ex_hold = 1'b0;

      // reset state
      #12;
      chk("rst_ex_valid", ex_valid, 1'b0);
      chk("rst_ex_pc", ex_pc, 64'h0);
      chk("rst_stall_count", stall_count, 4'd0);
      chk("rst_flush_count", flush_count, 4'd0);
      chk("rst_stall_if_id", stall_if_id, 1'b0);
      rst_n = 1'b1;

      // plain advance
      drive_id(1'b1, 64'h100, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0);
      id_rs1_data = 64'hAAAA; id_rs2_data = 64'hBBBB; id_imm = 64'h10;
      id_alu_op = 4'h3; id_alu_src = 1'b1;
      #1 chk("adv_stall", stall_if_id, 1'b0);
      tick();
      chk("adv_valid", ex_valid, 1'b1);
      chk("adv_pc", ex_pc, 64'h100);
      chk("adv_rs1_data", ex_rs1_data, 64'hAAAA);
      chk("adv_rs2_data", ex_rs2_data, 64'hBBBB);
      chk("adv_imm", ex_imm, 64'h10);
      chk("adv_rd", ex_rd, 5'd3);
      chk("adv_reg_write", ex_reg_write, 1'b1);
      chk("adv_alu_op", ex_alu_op, 4'h3);
      chk("adv_alu_src", ex_alu_src, 1'b1);

      // writeback bypass on rs2
      drive_id(1'b1, 64'h104, 5'd4, 5'd7, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0);
      id_rs1_data = 64'h44; id_rs2_data = 64'h11; id_alu_src = 1'b0;
      wb_reg_write = 1'b1; wb_rd = 5'd7; wb_data = 64'hDEAD;
      tick();
      chk("byp_rs2_data", ex_rs2_data, 64'hDEAD);
      chk("byp_rs1_data", ex_rs1_data, 64'h44);
      chk("byp_rs2", ex_rs2, 5'd7);

      // x0 reads zero despite writeback to x0
      id_rs2 = 5'd0; id_rs2_data = 64'h55;
      wb_rd = 5'd0; wb_data = 64'hBEEF;
      tick();
      chk("x0_rs2_data", ex_rs2_data, 64'h0);

      // empty slot gates control bits
      drive_id(1'b0, 64'h108, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b1, 1'b1);
      wb_reg_write = 1'b0;
      tick();
      chk("inv_valid", ex_valid, 1'b0);
      chk("inv_reg_write", ex_reg_write, 1'b0);
      chk("inv_mem_read", ex_mem_read, 1'b0);

      // load-use: ld x5 then add using x5
      drive_id(1'b1, 64'h1F0, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1);
      tick();
      chk("ld_mem_read", ex_mem_read, 1'b1);
      chk("ld_rd", ex_rd, 5'd5);
      drive_id(1'b1, 64'h200, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0, 1'b1, 1'b0);
      #1 chk("lu_stall", stall_if_id, 1'b1);
      tick();
      chk("lu_bubble_valid", ex_valid, 1'b0);
      chk("lu_bubble_reg_write", ex_reg_write, 1'b0);
      chk("lu_bubble_stall", stall_if_id, 1'b0);
      chk("lu_stall_count", stall_count, 4'd1);
      tick();
      chk("lu_adv_valid", ex_valid, 1'b1);
      chk("lu_adv_rs1", ex_rs1, 5'd5);
      chk("lu_adv_pc", ex_pc, 64'h200);
      chk("lu_stall_count2", stall_count, 4'd1);

      // load to x0 never raises a hazard
      drive_id(1'b1, 64'h2F0, 5'd1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1);
      tick();
      drive_id(1'b1, 64'h300, 5'd0, 5'd0, 5'd9, 1'b1, 1'b0, 1'b1, 1'b0);
      #1 chk("x0_load_no_stall", stall_if_id, 1'b0);
      tick();
      chk("x0_adv_pc", ex_pc, 64'h300);

      // hold for 3 cycles while ID changes
      ex_hold = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive_id(1'b1, 64'h400 + 64'(i), 5'd9, 5'd1, 5'd10 + 5'(i), 1'b1, 1'b1, 1'b0, 1'b1);
         #1 chk("hold_stall", stall_if_id, 1'b1);
         tick();
         chk("hold_pc", ex_pc, 64'h300);
         chk("hold_rd", ex_rd, 5'd9);
         chk("hold_valid", ex_valid, 1'b1);
         chk("hold_reg_write", ex_reg_write, 1'b1);
      end
      chk("hold_stall_count", stall_count, 4'd4);

      // flush beats hold and load-use
      ex_hold = 1'b0;
      drive_id(1'b1, 64'h500, 5'd1, 5'd0, 5'd8, 1'b1, 1'b0, 1'b1, 1'b1);
      tick();
      drive_id(1'b1, 64'h504, 5'd0, 5'd8, 5'd2, 1'b0, 1'b1, 1'b1, 1'b0);
      #1 chk("pre_flush_lu_stall", stall_if_id, 1'b1);
      ex_flush = 1'b1; ex_hold = 1'b1;
      #1 chk("flush_stall", stall_if_id, 1'b0);
      tick();
      chk("flush_valid", ex_valid, 1'b0);
      chk("flush_mem_read", ex_mem_read, 1'b0);
      chk("flush_count1", flush_count, 4'd1);
      chk("flush_stall_count", stall_count, 4'd4);

      // flush counter saturation
      ex_hold = 1'b0;
      for (int i = 0; i < 13; i++) tick();
      chk("flush_count14", flush_count, 4'd14);
      for (int i = 0; i < 7; i++) tick();
      chk("flush_count_sat", flush_count, 4'd15);
      chk("sat_stall_count", stall_count, 4'd4);

      // asynchronous reset mid-stream
      ex_flush = 1'b0;
      drive_id(1'b1, 64'h600, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      chk("pre_rst_valid", ex_valid, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_valid", ex_valid, 1'b0);
      chk("arst_pc", ex_pc, 64'h0);
      chk("arst_reg_write", ex_reg_write, 1'b0);
      chk("arst_flush_count", flush_count, 4'd0);
      chk("arst_stall_count", stall_count, 4'd0);
      chk("arst_stall", stall_if_id, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage of the RISC-V pipeline, directly downstream of the register file. It captures the decode-stage operands and control into the EX-stage register. It bypasses same-cycle writeback data into the captured operands, detects load-use hazards, and inserts bubbles on stall, hold or flush. It also keeps saturating performance counters for stall and flush events.

## Interface
- XLEN, 64, datapath width
- CNTW, 32, performance counter width

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  decode slot holds a real instruction
- id_pc  in  XLEN  instruction PC
- id_rs1, id_rs2, id_rd  in  5  register indices
- id_uses_rs1, id_uses_rs2  in  1  instruction actually reads rs1/rs2
- id_rs1_data, id_rs2_data  in  XLEN  register file read data
- id_imm  in  XLEN  decoded immediate
- id_reg_write, id_mem_read, id_mem_write, id_alu_src  in  1  control bits
- id_alu_op  in  4  ALU operation
- wb_reg_write  in  1  writeback enable (same signal driving register file regWrite)
- wb_rd  in  5  writeback index
- wb_data  in  XLEN  writeback data
- ex_flush  in  1  branch/jump redirect resolved in EX; kill ID and EX
- ex_hold  in  1  downstream not ready; freeze EX register
- stall_if_id  out  1  freeze PC and IF/ID register this cycle
- ex_valid  out  1  EX register holds a real instruction
- ex_pc, ex_imm, ex_rs1_data, ex_rs2_data  out  XLEN  registered copies
- ex_rs1, ex_rs2, ex_rd  out  5  registered indices
- ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src  out  1  registered control
- ex_alu_op  out  4  registered ALU op
- stall_count, flush_count  out  CNTW  saturating event counters

## Operation
- **Load-use hazard (combinational)**, `lu`, is asserted when all of the following hold:
  - ex_valid & ex_mem_read & ex_rd≠0 & id_valid, and
  - (id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd).
- **stall_if_id** = !ex_flush & (ex_hold | lu).
- **Next-state priority, one action per cycle:**
  - FLUSH (ex_flush): ex_valid←0, all ex control bits←0, data/index fields don't-care (hold old value).
  - HOLD (ex_hold): all EX registers keep their value.
  - BUBBLE (lu): same as FLUSH; the ID instruction is retained upstream by stall_if_id.
  - ADVANCE (otherwise): capture all id_* fields; ex_valid←id_valid; control bits are gated to 0 when id_valid=0.
- **Operand capture on ADVANCE, per operand n∈{1,2}:**
  - id_rsn==0 → 0.
  - else wb_reg_write & wb_rd==id_rsn → wb_data (bypass).
  - else → id_rsn_data.
- **Counters:**
  - stall_count +1 on each cycle with stall_if_id=1.
  - flush_count +1 on each cycle with ex_flush=1.
  - Both saturate at 2^CNTW−1 and never wrap.
- ex_rd==0 with ex_mem_read never raises lu.

## Timing
- Reset value of every registered output is 0, including ex_valid, all data, all counters. stall_if_id therefore reads 0 while rst_n=0 unless ex_hold=1.
- Reset is asynchronous assert and synchronous deassert. An instruction in EX at reset is dropped.
- Latency: ID→EX is 1 cycle. stall_if_id has the same-cycle combinational path from id_* and the EX registers.
- Load-use costs exactly 1 bubble: cycle N lu=1, stall; cycle N+1 EX holds the bubble, lu=0, and the instruction advances at edge N+1.
- ex_flush and ex_hold together: flush wins. EX is cleared and stall_if_id=0.
- ex_hold and lu together: hold wins. No bubble is inserted and lu is re-evaluated next cycle.
- The bypass uses wb_* in the same cycle as the capture edge only.

## Test plan
- **Reset mid-stream:** rst_n low asynchronously while ex_valid=1 → all outputs 0 immediately, without waiting for a clock edge.
- **Load-use:**
  - Stimulus: ld x5 in EX (ex_mem_read=1, ex_rd=5), then id add with rs1=5, uses_rs1=1.
  - Required: stall_if_id=1 for one cycle; next cycle ex_valid=0 with ex_reg_write=0; following cycle ex_rs1=5 and ex_valid=1; stall_count=1.
- **Bypass:**
  - Stimulus: id_rs2=7, id_rs2_data=0x11, wb_reg_write=1, wb_rd=7, wb_data=0xDEAD.
  - Required: ex_rs2_data=0xDEAD. With wb_rd=0 and id_rs2=0 → ex_rs2_data=0.
- **Flush priority:** ex_flush=1, ex_hold=1 and lu=1 simultaneously → stall_if_id=0, next ex_valid=0, flush_count+1, stall_count unchanged.
- **Hold:** ex_hold=1 for 3 cycles while id_* changes → ex_* constant across all 3 cycles, stall_if_id=1 each cycle, stall_count+3.
- **Counter saturation:** with CNTW=4, assert ex_flush for 20 cycles → flush_count stops at 15.
